// File: rtl/butterfly_in_xbar.sv
// -----------------------------------------------------------------------------
// butterfly_in_xbar
//   LANES x LANES input crossbar in front of the butterfly array. Each bank
//   read lane q[i] is steered to one operand port (u0,v0,u1,v1,...). The
//   per-lane selects are issued together with the bank read address and ride
//   a SEL_DELAY-deep delay line so that they meet the returning bank data.
//   An optional output register stage (OUT_REG) adds one cycle of latency.
//
//   Optional feature macro: BF_IN_COLLISION_CHK_EN
//     defined   : destination-collision flag and saturating counter are built
//     undefined : collision / collision_cnt are tied to 0
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   clr            synchronous flush of delay line, output stage and counter
//   sel_valid      sel/bypass valid this cycle (issued with bank address)
//   sel            lane i destination = sel[i*SEL_W +: SEL_W]
//   bypass         identity routing (lane i -> dest i), sel ignored
//   q              bank read data, lane i = q[i*DW +: DW]
//   dout           dest j = dout[j*DW +: DW]
//   dout_valid     dout holds a routed word
//   dout_mask      bit j set when dest j was driven by some lane
//   collision      two or more lanes targeted one dest (checker only)
//   collision_cnt  saturating count of colliding words (checker only)
// -----------------------------------------------------------------------------
module butterfly_in_xbar #(
    parameter int DW        = 12,
    parameter int LANES     = 4,
    parameter int SEL_W     = $clog2(LANES),
    parameter int SEL_DELAY = 1,
    parameter int OUT_REG   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   sel_valid,
    input  logic [LANES*SEL_W-1:0] sel,
    input  logic                   bypass,
    input  logic [LANES*DW-1:0]    q,
    output logic [LANES*DW-1:0]    dout,
    output logic                   dout_valid,
    output logic [LANES-1:0]       dout_mask,
    output logic                   collision,
    output logic [CNT_W-1:0]       collision_cnt
);

    // Select delay line: stage SEL_DELAY-1 is aligned with q.
    logic                   r_vld [SEL_DELAY];
    logic                   r_byp [SEL_DELAY];
    logic [LANES*SEL_W-1:0] r_sel [SEL_DELAY];

    // NOTE: the delay line is only a few flops, so every stage (not just the
    // valid bits) is reset; that keeps simulation free of X on the select path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SEL_DELAY; k++) begin
                r_vld[k] <= 1'b0;
                r_byp[k] <= 1'b0;
                r_sel[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the value
            // its predecessor held before this edge, forming a true shift.
            r_vld[0] <= sel_valid & ~clr;
            r_byp[0] <= bypass;
            r_sel[0] <= sel;
            for (int k = 1; k < SEL_DELAY; k++) begin
                r_vld[k] <= r_vld[k-1] & ~clr;
                r_byp[k] <= r_byp[k-1];
                r_sel[k] <= r_sel[k-1];
            end
        end
    end

    logic                   w_vld_d;
    logic                   w_byp_d;
    logic [LANES*SEL_W-1:0] w_sel_d;

    assign w_vld_d = r_vld[SEL_DELAY-1];
    assign w_byp_d = r_byp[SEL_DELAY-1];
    assign w_sel_d = r_sel[SEL_DELAY-1];

    // Routing: ascending lane order, so the highest-index lane wins a shared dest.
    logic [LANES*DW-1:0] w_route;
    logic [LANES-1:0]    w_mask;
    logic [SEL_W-1:0]    w_dst;

    always_comb begin
        // NOTE: every comb output gets a default before the loop; otherwise
        // dests that no lane touches would infer latches.
        w_route = '0;
        w_mask  = '0;
        w_dst   = '0;
        if (w_vld_d) begin
            for (int i = 0; i < LANES; i++) begin
                w_dst = w_byp_d ? SEL_W'(i) : w_sel_d[i*SEL_W +: SEL_W];
                w_route[w_dst*DW +: DW] = q[i*DW +: DW];
                w_mask[w_dst]           = 1'b1;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [LANES*DW-1:0] r_dout;
            logic [LANES-1:0]    r_mask;
            logic                r_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dout  <= '0;
                    r_mask  <= '0;
                    r_valid <= 1'b0;
                end else if (clr) begin
                    r_dout  <= '0;
                    r_mask  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_dout  <= w_route;
                    r_mask  <= w_mask;
                    r_valid <= w_vld_d;
                end
            end

            assign dout       = r_dout;
            assign dout_mask  = r_mask;
            assign dout_valid = r_valid;
        end else begin : g_ocomb
            assign dout       = w_route;
            assign dout_mask  = w_mask;
            assign dout_valid = w_vld_d;
        end
    endgenerate

`ifdef BF_IN_COLLISION_CHK_EN
    // LANES lanes map onto LANES dests, so two lanes share a dest exactly when
    // some dest is left undriven.
    logic             w_col;
    logic [CNT_W-1:0] r_cnt;

    assign w_col = w_vld_d & ~w_byp_d & (w_mask != {LANES{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_col && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign collision_cnt = r_cnt;

    generate
        if (OUT_REG != 0) begin : g_col_reg
            logic r_col;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_col <= 1'b0;
                end else if (clr) begin
                    r_col <= 1'b0;
                end else begin
                    r_col <= w_col;
                end
            end

            assign collision = r_col;
        end else begin : g_col_comb
            assign collision = w_col;
        end
    endgenerate
`else
    assign collision     = 1'b0;
    assign collision_cnt = '0;
`endif

endmodule
